// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift register and its sequencer
// Contents: OP_* operation encodings (also used as the shift-register sel code)
//           and the sequencer FSM state enum.
package usr_pkg;
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SETTLE = 2'b10
    } state_t;
endpackage

// File: rtl/usr.sv
// usr: 4-bit universal shift register
// Ports: clk, rst (async active-low); sel (OP_* code); d_in parallel load word;
//        s_in_left serial bit entering at bit 0 on SHL; s_in_right serial bit
//        entering at bit 3 on SHR; q register contents.
module usr
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sel,
    input  logic [3:0] d_in,
    input  logic       s_in_left,
    input  logic       s_in_right,
    output logic [3:0] q
);
    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = sel == OP_LOAD ? d_in :
              sel == OP_SHR  ? {s_in_right, q_q[3:1]} :
              sel == OP_SHL  ? {q_q[2:0], s_in_left} : q_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_q <= 4'b0000;
        else      q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/usr_seq.sv
// usr_seq: command sequencer driving a 4-bit universal shift register
// Ports: clk, rst (async active-low);
//        cmd_valid/cmd_ready/cmd_op/cmd_cnt/cmd_data/cmd_fill command handshake;
//        q_in shift-register readback; sel/d_in/s_in_left/s_in_right registered
//        shift-register controls; result/done/busy completion status.
// Option: define USR_SEQ_ABORT_EN to add abort (in) and aborted (out), which cut
//         a RUN short and flag the resulting completion.
module usr_seq
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_cnt,
    input  logic [3:0] cmd_data,
    input  logic       cmd_fill,
    input  logic [3:0] q_in,
    output logic [1:0] sel,
    output logic [3:0] d_in,
    output logic       s_in_left,
    output logic       s_in_right,
    output logic [3:0] result,
    output logic       done,
    output logic       busy
`ifdef USR_SEQ_ABORT_EN
    ,
    input  logic       abort,
    output logic       aborted
`endif
);
    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] d_in_q, d_in_d;
    logic       sl_q, sl_d;
    logic       sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] result_q, result_d;
    logic       done_q, done_d;
    logic       stop_run;

`ifdef USR_SEQ_ABORT_EN
    logic abt_q, abt_d;
    logic aborted_q, aborted_d;
    assign stop_run = cnt_q == 3'd0 || abort;
`else
    assign stop_run = cnt_q == 3'd0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        d_in_d   = d_in_q;
        sl_d     = sl_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
`ifdef USR_SEQ_ABORT_EN
        abt_d     = abt_q;
        aborted_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_RUN;
                    sel_d   = cmd_op;
                    d_in_d  = cmd_data;
                    sl_d    = cmd_fill && cmd_op == OP_SHL;
                    sr_d    = cmd_fill && cmd_op == OP_SHR;
                    // cnt holds remaining RUN cycles minus one; 0-1 wraps to 7, giving 8 cycles
                    cnt_d   = cmd_op == OP_LOAD ? 3'd0 : cmd_cnt - 3'd1;
`ifdef USR_SEQ_ABORT_EN
                    abt_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (stop_run) begin
                    state_d = ST_SETTLE;
                    sel_d   = OP_HOLD;
                    cnt_d   = 3'd0;
`ifdef USR_SEQ_ABORT_EN
                    abt_d   = abort;
`endif
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_SETTLE: begin
                state_d  = ST_IDLE;
                result_d = q_in;
                done_d   = 1'b1;
`ifdef USR_SEQ_ABORT_EN
                aborted_d = abt_q;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= OP_HOLD;
            d_in_q   <= 4'b0000;
            sl_q     <= 1'b0;
            sr_q     <= 1'b0;
            cnt_q    <= 3'd0;
            result_q <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            d_in_q   <= d_in_d;
            sl_q     <= sl_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

`ifdef USR_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abt_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            abt_q     <= abt_d;
            aborted_q <= aborted_d;
        end
    end

    assign aborted = aborted_q;
`endif

    assign cmd_ready  = state_q == ST_IDLE;
    assign busy       = state_q != ST_IDLE;
    assign sel        = sel_q;
    assign d_in       = d_in_q;
    assign s_in_left  = sl_q;
    assign s_in_right = sr_q;
    assign result     = result_q;
    assign done       = done_q;
endmodule
